// File: rtl/alu_mult_seq_pkg.sv
// alu_mult_seq_pkg: ALU opcodes, controller state encoding and step selection
package alu_mult_seq_pkg;
  localparam logic [2:0] OP_SHL = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b100;
  typedef enum logic [1:0] {S_IDLE, S_ADD, S_SHIFT, S_DONE} state_t;
  // Next step for a remaining multiplier: add on a set LSB, shift while higher bits remain.
  function automatic state_t pick(input logic [15:0] m);
    return m[0] ? S_ADD : (|m[15:1] ? S_SHIFT : S_DONE);
  endfunction
endpackage

// File: rtl/alu_mult_seq.sv
// alu_mult_seq: shift-and-add 16x16 multiply sequenced through the shared ALU
module alu_mult_seq
  import alu_mult_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] mcand,
  input  logic [15:0] mplier,
  output logic        busy,
  output logic        done,
  output logic [15:0] product,
  output logic        ofl,
  output logic        alu_req,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [2:0]  alu_op,
  output logic        alu_cin,
  output logic        alu_inva,
  output logic        alu_invb,
  output logic        alu_sign,
  input  logic [15:0] alu_out,
  input  logic        alu_ofl
);
  state_t state, next;
  logic [15:0] acc, mc, mp, mp_sh, product_r;
  logic ofl_r, ofl_q;
  assign mp_sh = mp >> 1;
  // State register and datapath; ALU results are only captured in ADD/SHIFT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      acc       <= '0;
      mc        <= '0;
      mp        <= '0;
      ofl_r     <= 1'b0;
      product_r <= '0;
      ofl_q     <= 1'b0;
    end else begin
      state <= next;
      if (state == S_IDLE && start) begin
        acc   <= '0;
        mc    <= mcand;
        mp    <= mplier;
        ofl_r <= 1'b0;
      end
      if (state == S_ADD) begin
        acc   <= alu_out;
        ofl_r <= ofl_r | alu_ofl;
      end
      if (state == S_SHIFT) begin
        mc    <= alu_out;
        mp    <= mp_sh;
        ofl_r <= ofl_r | mc[15];
      end
      if (state == S_DONE) begin
        product_r <= acc;
        ofl_q     <= ofl_r;
      end
    end
  end
  // Next state: SHIFT looks ahead at the multiplier after this cycle's shift.
  always_comb begin
    next = state;
    next = state == S_IDLE  ? (start ? pick(mplier) : S_IDLE) :
           state == S_ADD   ? (mp > 16'd1 ? S_SHIFT : S_DONE) :
           state == S_SHIFT ? pick(mp_sh) : S_IDLE;
  end
  // Status and ALU drive; result is forwarded during DONE so it is valid with done.
  always_comb begin
    busy     = state != S_IDLE;
    done     = state == S_DONE;
    alu_req  = busy;
    product  = done ? acc : product_r;
    ofl      = done ? ofl_r : ofl_q;
    alu_a    = state == S_ADD ? acc : state == S_SHIFT ? mc : 16'h0000;
    alu_b    = state == S_ADD ? mc : state == S_SHIFT ? 16'h0001 : 16'h0000;
    alu_op   = state == S_SHIFT ? OP_SHL : OP_ADD;
    alu_cin  = 1'b0;
    alu_inva = 1'b0;
    alu_invb = 1'b0;
    alu_sign = 1'b0;
  end
endmodule

// File: tb/tb_alu_mult_seq.sv
// tb_alu_mult_seq: directed checks of the multiply controller against a bench ALU model
module tb_alu_mult_seq;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [15:0] mcand = '0, mplier = '0;
  logic busy, done, ofl, alu_req, alu_cin, alu_inva, alu_invb, alu_sign, alu_ofl;
  logic [15:0] product, alu_a, alu_b, alu_out;
  logic [2:0] alu_op;
  logic [14:0] ops = '0;
  int total = 0, bad = 0, shl_cnt = 0, side_bad = 0;
  int cyc, n;

  alu_mult_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mcand(mcand), .mplier(mplier),
    .busy(busy), .done(done), .product(product), .ofl(ofl), .alu_req(alu_req),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
    .alu_inva(alu_inva), .alu_invb(alu_invb), .alu_sign(alu_sign),
    .alu_out(alu_out), .alu_ofl(alu_ofl)
  );

  always #5 clk = ~clk;

  // ALU model: 17-bit add gives carry on ofl; SHL shifts A by B[3:0].
  always_comb begin
    {alu_ofl, alu_out} = 17'd0;
    if (alu_op == 3'b100) {alu_ofl, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
    else if (alu_op == 3'b001) alu_out = alu_a << alu_b[3:0];
  end

  always @(negedge clk) begin
    if (alu_op == 3'b001) shl_cnt++;
    if ((alu_cin | alu_inva | alu_invb | alu_sign) !== 1'b0 || alu_req !== busy) side_bad++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [15:0] a, input logic [15:0] b, input bit hold,
                     input int poke, output int c);
    @(negedge clk);
    mcand = a; mplier = b; start = 1'b1;
    @(negedge clk);
    c = 1;
    ops = {12'd0, alu_op};
    while (done !== 1'b1 && c < 40) begin
      if (c == poke) begin
        start = 1'b1; mcand = 16'hFFFF; mplier = 16'hFFFF;
      end else start = hold;
      @(negedge clk);
      c++;
      ops = {ops[11:0], alu_op};
    end
    start = hold;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_product", product, 0);
    chk("rst_ofl", ofl, 0);
    chk("idle_op", alu_op, 3'b100);
    chk("idle_a", alu_a, 0);
    rst_n = 1'b1;

    run(16'd3, 16'd5, 0, 0, cyc);
    chk("3x5_cycles", cyc, 5);
    chk("3x5_done", done, 1);
    chk("3x5_product", product, 15);
    chk("3x5_ofl", ofl, 0);
    chk("3x5_ops", ops, 15'b100_001_001_100_100);
    repeat (3) @(negedge clk);
    chk("3x5_idle_busy", busy, 0);
    chk("3x5_hold_product", product, 15);

    mcand = 16'd3; mplier = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_product", product, 0);
    chk("midrst_ofl", ofl, 0);
    rst_n = 1'b1;
    run(16'd3, 16'd5, 0, 0, cyc);
    chk("after_rst_cycles", cyc, 5);
    chk("after_rst_product", product, 15);

    n = shl_cnt;
    run(16'h1234, 16'h0000, 0, 0, cyc);
    chk("zero_cycles", cyc, 1);
    chk("zero_product", product, 0);
    chk("zero_ofl", ofl, 0);
    chk("zero_no_shl", shl_cnt - n, 0);

    run(16'hFFFF, 16'hFFFF, 0, 0, cyc);
    chk("ffff_cycles", cyc, 32);
    chk("ffff_product", product, 16'h0001);
    chk("ffff_ofl", ofl, 1);

    run(16'h8000, 16'd2, 0, 0, cyc);
    chk("sh_ofl_cycles", cyc, 3);
    chk("sh_ofl_ops", ops[8:0], 9'b001_100_100);
    chk("sh_ofl_product", product, 0);
    chk("sh_ofl_ofl", ofl, 1);
    @(negedge clk);
    chk("sh_ofl_held", ofl, 1);

    run(16'h0100, 16'h0100, 0, 0, cyc);
    chk("c100_cycles", cyc, 10);
    chk("c100_product", product, 0);
    chk("c100_ofl", ofl, 1);

    run(16'd7, 16'd9, 0, 2, cyc);
    chk("poke_cycles", cyc, 6);
    chk("poke_product", product, 63);
    chk("poke_ofl", ofl, 0);
    @(negedge clk);
    chk("poke_idle", busy, 0);

    run(16'd3, 16'd5, 1, 0, cyc);
    chk("b2b_cycles", cyc, 5);
    chk("b2b_product", product, 15);
    @(negedge clk);
    chk("b2b_idle_busy", busy, 0);
    chk("b2b_idle_done", done, 0);
    @(negedge clk);
    chk("b2b_accept", busy, 1);
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("b2b_second_cycles", cyc, 5);
    chk("b2b_second_product", product, 15);

    chk("sideband", side_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
